bind_xor_kernel: RTL and testbench
==================================

// Module: bind_xor_kernel
// PURPOSE
//  Bind kernel fed by the direct bind mapper's k_* port. Accepts a framed stream of hypervector words
//  (first..last) for one HV offset and XOR-binds them, with an optional cyclic-permute step per operand.
//  Presents the bound word on data_out with a sticky done flag. The mapper then writes that word to HVC[offset].
// PARAMETERS
//  HV_DATA_WIDTH   32  word width W; every operand and the result are W bits
//  MAX_OPERANDS    4   maximum beats per frame (>=1)
//  PERMUTE_SHIFT   0   left-rotate step applied per operand index; 0 gives a pure XOR bind
// PORTS
//  clk        in   1     clock, rising edge
//  reset_n    in   1     asynchronous, active-low reset
//  valid      in   1     operand beat valid
//  first      in   1     beat is the first operand of a frame
//  last       in   1     beat is the last operand of a frame; may coincide with first
//  data_in    in   W     operand word
//  data_out   out  W     bound result, registered
//  ready      out  1     kernel can accept a beat this cycle
//  done       out  1     data_out holds a completed result (sticky)
//  err        out  1     one-cycle pulse on a protocol violation
//  op_count   out  clog2(MAX_OPERANDS+1)  beats accepted in the current or last frame
// BEHAVIOUR
//  Reset (async, any state): state=S_IDLE, acc=0, rot=0, data_out=0, done=0, err=0, op_count=0.
//    ready resets to 1.
//  ready = (state==S_IDLE | state==S_ACCUM), decoded from state.
//  A beat is accepted on a rising edge where valid & ready.
//  rotl(x,k) is a cyclic left rotate of x by k mod W. rot holds the current operand's shift amount.
//  S_IDLE:
//    - accepted first & ~last: acc<=data_in, rot<=PERMUTE_SHIFT%W, op_count<=1, done<=0 -> S_ACCUM.
//    - accepted first & last: data_out<=data_in, op_count<=1, done<=1 -> S_DONE.
//    - accepted beat without first: ignored, err<=1, state unchanged.
//  S_ACCUM:
//    - accepted ~first: v = acc ^ rotl(data_in,rot); op_count++; rot<=(rot+PERMUTE_SHIFT)%W.
//      If last: data_out<=v, done<=1 -> S_DONE. Otherwise acc<=v and stay.
//    - accepted first: err<=1; frame restarts exactly as from S_IDLE with this beat (incl. first&last).
//    - accepted ~first & ~last with op_count==MAX_OPERANDS-1: err<=1, beat treated as last.
//      Frame closes; op_count never exceeds MAX_OPERANDS.
//  S_DONE: lasts exactly 1 cycle with ready=0, then -> S_IDLE.
//    done stays 1 and data_out stays stable until the next accepted first beat clears done.
//  Latency: result on data_out and done=1 one cycle after the edge that accepts the last beat.
//    ready is low for exactly that one cycle.
//  err is high for exactly one cycle per violation; all other cycles err=0.
//  Throughput: N-beat frame plus the S_DONE cycle gives N+1 cycles minimum per frame.
//  Width rules: rot is clog2(W) bits and wraps modulo W. No carries anywhere; XOR is bitwise.
//  valid low: no state change. first/last/data_in are don't-care unless valid & ready.
//  Reset mid-frame: acc, done and data_out are cleared immediately; the partial frame is discarded.
// TESTING
//  T1 W=8, SHIFT=0: beats 0xA5(first), 0x0F(last)
//     -> data_out=0xAA and done=1 one cycle later; ready=0 that cycle; op_count=2.
//  T2 W=8, SHIFT=1: beats 0x01(first), 0x01, 0x01(last)
//     -> 0x01^0x02^0x04 = 0x07; op_count=3.
//  T3 single beat first&last 0x3C -> data_out=0x3C, done=1; done stays 1 until the next first beat.
//  T4 in IDLE, beat 0x55 without first -> err pulses 1 cycle, done/data_out unchanged.
//     Then first in ACCUM -> err pulse and the frame restarts from the new beat.
//  T5 MAX_OPERANDS=2: beats 0x11(first), 0x22 without last
//     -> err pulse, data_out=0x33, done=1, op_count=2.
//  T6 reset_n low mid-frame after 1 beat -> data_out=0, done=0, ready=1.
//     A following 2-beat frame then yields the correct XOR.

Source files
------------

// File: rtl/bind_xor_kernel.sv
// bind_xor_kernel
//   XOR-bind kernel for one hypervector offset. It accepts a framed stream of
//   operand words (first..last) and folds them as
//     result = op0 ^ rotl(op1, S) ^ rotl(op2, 2S) ^ ...   (shift amounts mod W)
//   The result is registered on data_out together with a sticky done flag.
//
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   valid     in   operand beat valid
//   first     in   beat opens a frame
//   last      in   beat closes a frame (may coincide with first)
//   data_in   in   operand word, W bits
//   data_out  out  bound result, registered, W bits
//   ready     out  kernel accepts a beat this cycle
//   done      out  data_out holds a completed result (sticky until next first beat)
//   err       out  one-cycle pulse on a protocol violation
//   op_count  out  beats accepted in the current or last frame
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a first beat
// S_ACCUM | frame open, acc holds the partial XOR
// S_DONE  | one-cycle result presentation, ready=0
module bind_xor_kernel #(
    parameter int HV_DATA_WIDTH = 32,
    parameter int MAX_OPERANDS  = 4,
    parameter int PERMUTE_SHIFT = 0
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               valid,
    input  logic                               first,
    input  logic                               last,
    input  logic [HV_DATA_WIDTH-1:0]           data_in,
    output logic [HV_DATA_WIDTH-1:0]           data_out,
    output logic                               ready,
    output logic                               done,
    output logic                               err,
    output logic [$clog2(MAX_OPERANDS+1)-1:0]  op_count
);

    localparam int W     = HV_DATA_WIDTH;
    localparam int ROT_W = (W > 1) ? $clog2(W) : 1;
    localparam int OPC_W = $clog2(MAX_OPERANDS + 1);

    localparam logic [ROT_W-1:0] ROT_STEP = ROT_W'(PERMUTE_SHIFT % W);
    localparam logic [ROT_W:0]   ROT_MOD  = (ROT_W+1)'(W);
    localparam logic [OPC_W-1:0] OPC_LAST = OPC_W'(MAX_OPERANDS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [ROT_W-1:0] rot_q, rot_d;
    logic [W-1:0]     data_out_q, data_out_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [OPC_W-1:0] op_count_q, op_count_d;

    logic             accept;
    logic [W-1:0]     bound;
    logic [ROT_W:0]   rot_sum;
    logic [ROT_W-1:0] rot_next;

    // Rotating the doubled word left by k leaves rotl(x,k) in the upper half.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [ROT_W-1:0] k);
        logic [2*W-1:0] t;
        t = {x, x} << k;
        return t[2*W-1:W];
    endfunction

    assign ready = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign accept = valid & ready;
    assign bound  = acc_q ^ rotl(data_in, rot_q);

    // rot + step, reduced mod W without relying on W being a power of two.
    always_comb begin
        rot_sum  = {1'b0, rot_q} + {1'b0, ROT_STEP};
        rot_next = rot_q;
        if (rot_sum >= ROT_MOD) begin
            rot_next = ROT_W'(rot_sum - ROT_MOD);
        end else begin
            rot_next = rot_sum[ROT_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        rot_d      = rot_q;
        data_out_d = data_out_q;
        done_d     = done_q;
        err_d      = 1'b0;
        op_count_d = op_count_q;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    if (first) begin
                        // A first beat inside an open frame restarts the frame.
                        if (state_q == S_ACCUM) begin
                            err_d = 1'b1;
                        end
                        op_count_d = OPC_W'(1);
                        if (last || (MAX_OPERANDS == 1)) begin
                            if (!last) begin
                                err_d = 1'b1;
                            end
                            data_out_d = data_in;
                            done_d     = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            acc_d   = data_in;
                            rot_d   = ROT_STEP;
                            done_d  = 1'b0;
                            state_d = S_ACCUM;
                        end
                    end else if (state_q == S_IDLE) begin
                        err_d = 1'b1;
                    end else begin
                        op_count_d = op_count_q + OPC_W'(1);
                        rot_d      = rot_next;
                        // The beat that fills the operand budget closes the frame.
                        if (last || (op_count_q == OPC_LAST)) begin
                            if (!last) begin
                                err_d = 1'b1;
                            end
                            data_out_d = bound;
                            done_d     = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            acc_d = bound;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            rot_q      <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            rot_q      <= rot_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            err_q      <= err_d;
            op_count_q <= op_count_d;
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;
    assign err      = err_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_bind_xor_kernel.sv
// Testbench for bind_xor_kernel. Three instances (W=8):
//   d0: SHIFT=0, MAX=4   d1: SHIFT=1, MAX=4   d2: SHIFT=0, MAX=2
// Expected results are queued as frames are issued; a monitor pops and
// compares whenever an instance presents a result (ready low = S_DONE).
module tb_bind_xor_kernel;

    logic       clk;
    logic       reset_n;
    logic       valid [3];
    logic       first [3];
    logic       last  [3];
    logic [7:0] din   [3];
    logic [7:0] dout  [3];
    logic       rdy   [3];
    logic       done  [3];
    logic       err   [3];
    logic [2:0] opc   [3];
    logic [2:0] opc0, opc1;
    logic [1:0] opc2;

    logic [15:0] exp_q [3][$];
    logic [15:0] e;

    int checks;
    int failures;

    bind_xor_kernel #(.HV_DATA_WIDTH(8), .MAX_OPERANDS(4), .PERMUTE_SHIFT(0)) u0 (
        .clk(clk), .reset_n(reset_n), .valid(valid[0]), .first(first[0]), .last(last[0]),
        .data_in(din[0]), .data_out(dout[0]), .ready(rdy[0]), .done(done[0]), .err(err[0]),
        .op_count(opc0));
    bind_xor_kernel #(.HV_DATA_WIDTH(8), .MAX_OPERANDS(4), .PERMUTE_SHIFT(1)) u1 (
        .clk(clk), .reset_n(reset_n), .valid(valid[1]), .first(first[1]), .last(last[1]),
        .data_in(din[1]), .data_out(dout[1]), .ready(rdy[1]), .done(done[1]), .err(err[1]),
        .op_count(opc1));
    bind_xor_kernel #(.HV_DATA_WIDTH(8), .MAX_OPERANDS(2), .PERMUTE_SHIFT(0)) u2 (
        .clk(clk), .reset_n(reset_n), .valid(valid[2]), .first(first[2]), .last(last[2]),
        .data_in(din[2]), .data_out(dout[2]), .ready(rdy[2]), .done(done[2]), .err(err[2]),
        .op_count(opc2));

    assign opc[0] = opc0;
    assign opc[1] = opc1;
    assign opc[2] = {1'b0, opc2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    // Drive one beat at the falling edge once ready, hold it through the rising edge.
    task automatic send(input int d, input logic f, input logic l, input logic [7:0] x);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout dut=%0d actual=0 expected=1", d);
        end
        valid[d] = 1'b1;
        first[d] = f;
        last[d]  = l;
        din[d]   = x;
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        first[d] = 1'b0;
        last[d]  = 1'b0;
    endtask

    task automatic expect_result(input int d, input logic [7:0] data, input logic [7:0] cnt);
        exp_q[d].push_back({cnt, data});
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            for (int d = 0; d < 3; d++) begin
                if (!rdy[d]) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result dut=%0d actual=0x%0h expected=none", d, dout[d]);
                    end else begin
                        e = exp_q[d].pop_front();
                        chk($sformatf("result_data_d%0d", d), {8'h0, dout[d]}, {8'h0, e[7:0]});
                        chk($sformatf("result_opc_d%0d", d), {13'h0, opc[d]}, {8'h0, e[15:8]});
                        chk($sformatf("result_done_d%0d", d), {15'h0, done[d]}, 16'h1);
                    end
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int d = 0; d < 3; d++) begin
            valid[d] = 1'b0;
            first[d] = 1'b0;
            last[d]  = 1'b0;
            din[d]   = 8'h00;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_dout", {8'h0, dout[d]}, 16'h0);
            chk("reset_done", {15'h0, done[d]}, 16'h0);
            chk("reset_ready", {15'h0, rdy[d]}, 16'h1);
            chk("reset_err", {15'h0, err[d]}, 16'h0);
            chk("reset_opc", {13'h0, opc[d]}, 16'h0);
        end
        reset_n = 1'b1;

        // T1: 0xA5 ^ 0x0F
        expect_result(0, 8'hAA, 8'd2);
        send(0, 1'b1, 1'b0, 8'hA5);
        send(0, 1'b0, 1'b1, 8'h0F);
        repeat (3) @(negedge clk);
        chk("t1_done_sticky", {15'h0, done[0]}, 16'h1);
        chk("t1_ready_back", {15'h0, rdy[0]}, 16'h1);
        chk("t1_dout_stable", {8'h0, dout[0]}, 16'h00AA);

        // T2: permute by 1 per operand
        expect_result(1, 8'h07, 8'd3);
        send(1, 1'b1, 1'b0, 8'h01);
        send(1, 1'b0, 1'b0, 8'h01);
        send(1, 1'b0, 1'b1, 8'h01);

        // rotation of the MSB wraps: 0x80 ^ 0x01 ^ 0x02 ^ 0x04
        expect_result(1, 8'h87, 8'd4);
        send(1, 1'b1, 1'b0, 8'h80);
        send(1, 1'b0, 1'b0, 8'h80);
        send(1, 1'b0, 1'b0, 8'h80);
        send(1, 1'b0, 1'b1, 8'h80);

        // T3: single-beat frame
        expect_result(0, 8'h3C, 8'd1);
        send(0, 1'b1, 1'b1, 8'h3C);
        repeat (4) @(negedge clk);
        chk("t3_done_sticky", {15'h0, done[0]}, 16'h1);
        chk("t3_dout", {8'h0, dout[0]}, 16'h003C);

        // T4: beat without first in idle
        send(0, 1'b0, 1'b0, 8'h55);
        chk("t4_idle_err", {15'h0, err[0]}, 16'h1);
        chk("t4_idle_done", {15'h0, done[0]}, 16'h1);
        chk("t4_idle_dout", {8'h0, dout[0]}, 16'h003C);
        @(posedge clk);
        #1;
        chk("t4_err_one_cycle", {15'h0, err[0]}, 16'h0);
        send(0, 1'b1, 1'b0, 8'h10);
        chk("t4_first_clears_done", {15'h0, done[0]}, 16'h0);
        chk("t4_no_err_first", {15'h0, err[0]}, 16'h0);
        send(0, 1'b1, 1'b0, 8'h20);
        chk("t4_restart_err", {15'h0, err[0]}, 16'h1);
        chk("t4_restart_opc", {13'h0, opc[0]}, 16'h1);
        expect_result(0, 8'h24, 8'd2);
        send(0, 1'b0, 1'b1, 8'h04);
        chk("t4_last_no_err", {15'h0, err[0]}, 16'h0);

        // Operand budget on d0 (MAX=4): fourth beat without last closes the frame
        expect_result(0, 8'h0F, 8'd4);
        send(0, 1'b1, 1'b0, 8'h01);
        send(0, 1'b0, 1'b0, 8'h02);
        send(0, 1'b0, 1'b0, 8'h04);
        send(0, 1'b0, 1'b0, 8'h08);
        chk("max4_err", {15'h0, err[0]}, 16'h1);

        // T5: MAX=2, second beat without last
        expect_result(2, 8'h33, 8'd2);
        send(2, 1'b1, 1'b0, 8'h11);
        send(2, 1'b0, 1'b0, 8'h22);
        chk("t5_err", {15'h0, err[2]}, 16'h1);
        @(posedge clk);
        #1;
        chk("t5_err_one_cycle", {15'h0, err[2]}, 16'h0);
        chk("t5_done", {15'h0, done[2]}, 16'h1);

        // T6: reset mid-frame
        send(0, 1'b1, 1'b0, 8'h77);
        reset_n = 1'b0;
        #1;
        chk("t6_dout", {8'h0, dout[0]}, 16'h0);
        chk("t6_done", {15'h0, done[0]}, 16'h0);
        chk("t6_ready", {15'h0, rdy[0]}, 16'h1);
        chk("t6_opc", {13'h0, opc[0]}, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        expect_result(0, 8'h99, 8'd2);
        send(0, 1'b1, 1'b0, 8'h5A);
        send(0, 1'b0, 1'b1, 8'hC3);

        repeat (4) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("pending_results_d%0d", d), 16'(exp_q[d].size()), 16'h0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
